output_channel_credit_tracker: RTL
==================================

// Module: output_channel_credit_tracker
// PURPOSE
//   Credit-based occupancy tracker for the PE output channels. Holds one credit counter per
//   channel, sized to the downstream channel buffer depth. Consumes credits when an instruction
//   issues writes, and restores them when downstream consumers dequeue.
//   Produces the registered output_channel_full_status vector that trigger resolution consumes.
//   The pessimistic per-stage updaters then refine that vector for instructions still in flight.
// PARAMETERS
//   CREDIT_DEPTH   4   credits per channel (downstream buffer slots); must be >= 1
// PORTS
//   clock                              input   1                         PE clock
//   reset                              input   1                         async, active-high
//   credit_reinit                      input   1                         sync pulse: restore all credits
//   issue_valid                        input   1                         instruction commits this cycle
//   issue_oci                          input   TIA_OCI_WIDTH             output channel index mask of issuing instr
//   credit_return                      input   TIA_NUM_OUTPUT_CHANNELS   one dequeue pulse per channel
//   output_channel_full_status         output  TIA_NUM_OUTPUT_CHANNELS   1 = channel has zero credits
//   output_channel_credit_count        output  NUM_CH*CW                 packed per-channel counts; CW=$clog2(CREDIT_DEPTH+1)
//   credit_error (TIA_CREDIT_ERROR_DETECT_EN only)  output  1           sticky protocol violation flag
// BEHAVIOUR
//   - Reset (async assert, sync release): all counters = CREDIT_DEPTH.
//     output_channel_full_status = 0; credit_error = 0.
//   - Per channel i, per cycle:
//     take_i = issue_valid & issue_oci[i]; give_i = credit_return[i].
//   - Only bits [TIA_NUM_OUTPUT_CHANNELS-1:0] of issue_oci are used; any higher bits are ignored.
//   - Counter update, registered:
//     - take & !give: count-1.
//     - give & !take: count+1.
//     - take & give: unchanged (net zero, legal even at count 0 or CREDIT_DEPTH).
//   - Saturation:
//     - take with no give at count 0: count holds 0 (underflow).
//     - give with no take at CREDIT_DEPTH: count holds CREDIT_DEPTH (overflow).
//   - output_channel_full_status[i] is registered and equals (next count == 0).
//     It updates in the same edge as the count; latency 1 cycle from take/give.
//     No combinational path from inputs to outputs.
//   - credit_reinit: all counters = CREDIT_DEPTH and full_status = 0 next cycle.
//     It overrides take/give in the same cycle. credit_error is not cleared.
//   - Reset asserted mid-operation: immediate return to reset values, pending takes/gives dropped.
//   - Channels are fully independent; any combination of channels may take/give in one cycle.
// CONFIGURATION
//   TIA_CREDIT_ERROR_DETECT_EN defined:
//     - Port credit_error is present.
//     - Set on any underflow or overflow event (either saturating case above) on any channel.
//     - Sticky until reset; registered, visible the cycle after the offending event.
//   TIA_CREDIT_ERROR_DETECT_EN undefined:
//     - Port credit_error and its logic are absent.
//     - Saturation behaviour is identical.
// STRUCTURE
//   - control.svh supplies TIA_NUM_OUTPUT_CHANNELS and TIA_OCI_WIDTH.
//   - control.svh also gains TIA_OUTPUT_CHANNEL_CREDIT_DEPTH (default for CREDIT_DEPTH).
//   - Sub-module output_channel_credit_counter: one saturating up/down counter with reinit.
//     It outputs count, full and an error pulse, and is instantiated TIA_NUM_OUTPUT_CHANNELS
//     times in a generate loop.
//   - Top level: take/give decode, error OR-reduction and sticky register.
// TESTING
//   1 Reset, then idle 5 cycles -> all counts = 4, full_status = 0, credit_error = 0.
//   2 issue_oci = 'b01 for 4 consecutive cycles, no returns -> ch0 count 3,2,1,0.
//     full_status[0] = 1 the cycle after the 4th issue; ch1 stays at 4.
//   3 ch0 at count 0: issue + credit_return[0] in the same cycle -> count stays 0, full stays 1.
//     With the macro, credit_error stays 0.
//   4 ch0 at count 0: issue with no return -> count holds 0.
//     With the macro, credit_error = 1 next cycle and stays 1 through a later credit_reinit.
//   5 ch1 at count 4: credit_return[1] alone -> count holds 4.
//     With the macro, credit_error = 1; without it, there is no credit_error port.
//   6 Counts {ch0 = 1, ch1 = 2}: assert credit_reinit together with issue_oci = 'b11 ->
//     both counts = 4 and full = 0 next cycle.
//     Then assert reset mid-sequence -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/output_channel_credit_tracker_pkg.sv
// Shared control constants for the PE output-channel credit tracker (channel count, OCI width,
// default credit depth) plus a helper to size credit counters.
package output_channel_credit_tracker_pkg;
   localparam int TIA_NUM_OUTPUT_CHANNELS         = 2;
   localparam int TIA_OCI_WIDTH                   = 4;
   localparam int TIA_OUTPUT_CHANNEL_CREDIT_DEPTH = 4;

   // Counter must hold every value 0..depth inclusive.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/output_channel_credit_counter.sv
// One saturating up/down credit counter with synchronous reinit; registered count and full flag,
// combinational error pulse on an underflow/overflow attempt.
module output_channel_credit_counter
   import output_channel_credit_tracker_pkg::*;
#(
   parameter int CREDIT_DEPTH = TIA_OUTPUT_CHANNEL_CREDIT_DEPTH,
   parameter int CW           = credit_width(CREDIT_DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          credit_reinit,
   input  logic          take,
   input  logic          give,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          err
);
   localparam logic [CW-1:0] DEPTH_C = CW'(CREDIT_DEPTH);

   logic [CW-1:0] count_d, count_q;
   logic          full_d, full_q;

   always_comb begin
      count_d = count_q;
      err     = 1'b0;
      if (credit_reinit) begin
         count_d = DEPTH_C;
      end else if (take && !give) begin
         if (count_q == '0) err = 1'b1;
         else               count_d = count_q - CW'(1);
      end else if (give && !take) begin
         if (count_q == DEPTH_C) err = 1'b1;
         else                    count_d = count_q + CW'(1);
      end
      // Full tracks the next count so both land on the same edge.
      full_d = (count_d == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= DEPTH_C;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign count = count_q;
   assign full  = full_q;
endmodule

// File: rtl/output_channel_credit_tracker.sv
// Per-channel credit tracker producing the registered output_channel_full_status vector.
// Optional sticky credit_error port when TIA_CREDIT_ERROR_DETECT_EN is defined.
module output_channel_credit_tracker
   import output_channel_credit_tracker_pkg::*;
#(
   parameter  int CREDIT_DEPTH = TIA_OUTPUT_CHANNEL_CREDIT_DEPTH,
   localparam int CW           = credit_width(CREDIT_DEPTH),
   localparam int NUM_CH       = TIA_NUM_OUTPUT_CHANNELS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     credit_reinit,
   input  logic                     issue_valid,
   input  logic [TIA_OCI_WIDTH-1:0] issue_oci,
   input  logic [NUM_CH-1:0]        credit_return,
   output logic [NUM_CH-1:0]        output_channel_full_status,
`ifdef TIA_CREDIT_ERROR_DETECT_EN
   output logic [NUM_CH*CW-1:0]     output_channel_credit_count,
   output logic                     credit_error
`else
   output logic [NUM_CH*CW-1:0]     output_channel_credit_count
`endif
);
   logic [NUM_CH-1:0] take, give, err_pulse;

   always_comb begin
      take = {NUM_CH{issue_valid}} & issue_oci[NUM_CH-1:0];
      give = credit_return;
   end

   generate
      if (TIA_OCI_WIDTH > NUM_CH) begin : g_oci_hi
         // Mask bits beyond the channel count carry no meaning here.
         logic unused_oci_hi;
         assign unused_oci_hi = ^issue_oci[TIA_OCI_WIDTH-1:NUM_CH];
      end
   endgenerate

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      output_channel_credit_counter #(
         .CREDIT_DEPTH (CREDIT_DEPTH),
         .CW           (CW)
      ) u_cnt (
         .clock         (clock),
         .reset         (reset),
         .credit_reinit (credit_reinit),
         .take          (take[i]),
         .give          (give[i]),
         .count         (output_channel_credit_count[i*CW +: CW]),
         .full          (output_channel_full_status[i]),
         .err           (err_pulse[i])
      );
   end

`ifdef TIA_CREDIT_ERROR_DETECT_EN
   logic credit_error_d, credit_error_q;

   always_comb begin
      credit_error_d = credit_error_q | (|err_pulse);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) credit_error_q <= 1'b0;
      else       credit_error_q <= credit_error_d;
   end

   assign credit_error = credit_error_q;
`else
   logic unused_err_pulse;
   assign unused_err_pulse = |err_pulse;
`endif
endmodule
